// File: rtl/capi_get_bfr_drain_pkg.sv
// Shared CAPI get-buffer drain definitions.
// FSM encoding and buffer geometry.
package capi_get_bfr_drain_pkg;

  localparam logic [1:0] s_idle  = 2'd0;
  localparam logic [1:0] s_read  = 2'd1;
  localparam logic [1:0] s_drain = 2'd2;
  localparam logic [1:0] s_stat  = 2'd3;

  localparam int unsigned beats_per_bfr = 4;

endpackage

// File: rtl/capi_drain_skid.sv
// Two-entry fall-through skid buffer for the drain data path.
// Empty buffer passes input straight through.
module capi_drain_skid #(
  parameter int dw = 129
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_v,
  input  logic [dw-1:0] in_d,
  output logic          out_v,
  input  logic          out_r,
  output logic [dw-1:0] out_d,
  output logic [1:0]    cnt
);

  logic [dw-1:0] mem [2];
  logic          rd;
  logic          wr;
  logic [1:0]    n;
  logic          push;
  logic          pop;
  logic          empty;

  assign empty = (n == 2'd0);
  assign out_v = in_v | ~empty;
  assign out_d = !empty ? mem[rd] :
                 in_v   ? in_d    : '0;
  assign pop   = ~empty & out_r;
  // a beat taken straight through never occupies an entry
  assign push  = in_v & ~(empty & out_r);
  assign cnt   = n;

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= in_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd <= 1'b0;
      wr <= 1'b0;
      n  <= 2'd0;
    end else begin
      if (push) wr <= ~wr;
      if (pop)  rd <= ~rd;
      n <= n + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/capi_get_bfr_drain.sv
// Drains completed get buffers from data RAM to the outbound
// beat stream, releases tags and reports end-of-transfer status.
module capi_get_bfr_drain
  import capi_get_bfr_drain_pkg::*;
#(
  parameter int tag_width  = 4,
  parameter int beat_width = $clog2(beats_per_bfr),
  parameter int data_width = 128,
  parameter int rc_width   = 8,
  parameter int bcnt_width = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_rd_v,
  output logic                            i_rd_r,
  input  logic [tag_width-1:0]            i_rd_id,
  input  logic [rc_width-1:0]             i_rd_rc,
  input  logic [bcnt_width-1:0]           i_rd_cnt,
  input  logic                            i_rd_e,
  output logic                            o_mem_re,
  output logic [tag_width+beat_width-1:0] o_mem_ra,
  input  logic [data_width-1:0]           i_mem_rd,
  output logic                            o_d_v,
  input  logic                            o_d_r,
  output logic [data_width-1:0]           o_d_d,
  output logic                            o_d_last,
  output logic                            o_st_v,
  input  logic                            o_st_r,
  output logic [rc_width-1:0]             o_st_rc,
  output logic [bcnt_width-1:0]           o_st_cnt,
  output logic                            o_free_v,
  output logic [tag_width-1:0]            o_free_id
);

  logic [1:0]            state;
  logic [tag_width-1:0]  id;
  logic [rc_width-1:0]   rc;
  logic [bcnt_width-1:0] cnt;
  logic                  e;
  logic [beat_width-1:0] beat;
  logic                  pend;
  logic                  pend_last;
  logic                  free_v;
  logic [1:0]            held;
  logic                  accept;
  logic                  rc_ok;
  logic                  issue;
  logic                  last_beat;

  assign i_rd_r    = (state == s_idle);
  assign accept    = i_rd_v & i_rd_r;
  assign rc_ok     = (i_rd_rc == '0);
  assign last_beat = &beat;
  // reads in flight plus held beats never exceed the two skid slots
  assign issue     = (state == s_read) &
                     ((held + {1'b0, pend}) < 2'd2);

  assign o_mem_re  = issue;
  assign o_mem_ra  = {id, beat};
  assign o_free_v  = free_v;
  assign o_free_id = id;
  assign o_st_v    = (state == s_stat);
  assign o_st_rc   = o_st_v ? rc  : '0;
  assign o_st_cnt  = o_st_v ? cnt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= s_idle;
      id        <= '0;
      rc        <= '0;
      cnt       <= '0;
      e         <= 1'b0;
      beat      <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      free_v    <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue & last_beat;
      free_v    <= (accept & ~rc_ok) | (issue & last_beat);
      unique case (state)
        s_idle: begin
          if (accept) begin
            id    <= i_rd_id;
            rc    <= i_rd_rc;
            cnt   <= i_rd_cnt;
            e     <= i_rd_e;
            state <= rc_ok ? s_read : s_drain;
          end
        end
        s_read: begin
          if (issue) begin
            beat <= beat + 1'b1;
            if (last_beat) state <= s_drain;
          end
        end
        s_drain: begin
          if (!pend && held == 2'd0)
            state <= e ? s_stat : s_idle;
        end
        s_stat: begin
          if (o_st_r) state <= s_idle;
        end
        default: state <= s_idle;
      endcase
    end
  end

  capi_drain_skid #(
    .dw(data_width + 1)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .in_v (pend),
    .in_d ({pend_last, i_mem_rd}),
    .out_v(o_d_v),
    .out_r(o_d_r),
    .out_d({o_d_last, o_d_d}),
    .cnt  (held)
  );

endmodule
